// File: rtl/uart_rx_code_loader_if.sv
// ---------------------------------------------------------------------------
// uart_rx_code_loader_if
// Code-memory write bus driven by the UART code loader.
//   write_enable_to_mem : single-cycle write strobe
//   address_to_mem      : word address, valid with the strobe and held after
//   data_to_mem         : word data, valid with the strobe and held after
// Modports: master (loader side, drives the bus), slave (memory side).
// ---------------------------------------------------------------------------
interface uart_rx_code_loader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
);
   logic              write_enable_to_mem;
   logic [ADDR_W-1:0] address_to_mem;
   logic [DATA_W-1:0] data_to_mem;

   modport master (
      output write_enable_to_mem,
      output address_to_mem,
      output data_to_mem
   );

   modport slave (
      input write_enable_to_mem,
      input address_to_mem,
      input data_to_mem
   );
endinterface

// File: rtl/uart_rx_code_loader.sv
// ---------------------------------------------------------------------------
// uart_rx_code_loader
// Receives the program image over a UART line (8N1), packs byte pairs
// big-endian into 16-bit words and writes them to consecutive code-memory
// addresses starting at 0. After WORD_COUNT words load_done rises and stays
// high; later frames are still checked but never written.
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   uart_rx      : serial input, idle high, asynchronous to clk
//   mem          : code-memory write bus (uart_rx_code_loader_if.master)
//   load_done    : sticky, all WORD_COUNT words written
//   frame_err    : sticky, at least one bad frame seen
//   words_loaded : number of words written so far
//
// Build option: define PARITY_EN for 8E1 frames (even parity bit checked
// between the data bits and the stop bit; a mismatch counts as a bad frame).
// ---------------------------------------------------------------------------
module uart_rx_code_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 16,
   parameter int WORD_COUNT   = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        uart_rx,
   uart_rx_code_loader_if.master       mem,
   output logic                        load_done,
   output logic                        frame_err,
   output logic [ADDR_W:0]             words_loaded
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

`ifdef PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t              state_q, state_d;
   logic                rx_meta_q, rx_sync_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          shift_q, shift_d;
   logic [7:0]          hi_byte_q, hi_byte_d;
   logic                hi_phase_q, hi_phase_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic                done_q, done_d;
   logic                ferr_q, ferr_d;
`ifdef PARITY_EN
   logic                par_err_q, par_err_d;
`endif

   logic                cnt_zero;
   logic                byte_ok;
   logic                byte_bad;
   logic [ADDR_W:0]     words_inc;

   assign cnt_zero  = (cnt_q == '0);
   assign words_inc = words_q + 1'b1;

   // State and datapath registers; the synchroniser idles high like the line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         hi_byte_q  <= '0;
         hi_phase_q <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         words_q    <= '0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= uart_rx;
         rx_sync_q  <= rx_meta_q;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         hi_byte_q  <= hi_byte_d;
         hi_phase_q <= hi_phase_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         words_q    <= words_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
`ifdef PARITY_EN
         par_err_q  <= par_err_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rx_sync_q) state_d = S_START;
         // A start bit that is high again at mid-bit was a glitch.
         S_START: if (cnt_zero) state_d = rx_sync_q ? S_IDLE : S_DATA;
`ifdef PARITY_EN
         S_DATA:  if (cnt_zero && bit_idx_q == 3'd7) state_d = S_PAR;
         S_PAR:   if (cnt_zero) state_d = S_STOP;
`else
         S_DATA:  if (cnt_zero && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
         // Leave right after the mid-bit sample so a start bit that follows
         // immediately is still caught.
         S_STOP:  if (cnt_zero) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bit timing, deserialiser and word assembly.
   always_comb begin
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      hi_byte_d  = hi_byte_q;
      hi_phase_d = hi_phase_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      words_d    = words_q;
      done_d     = done_q;
      ferr_d     = ferr_q;
      byte_ok    = 1'b0;
      byte_bad   = 1'b0;
`ifdef PARITY_EN
      par_err_d  = par_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            cnt_d = CNT_HALF;
`ifdef PARITY_EN
            par_err_d = 1'b0;
`endif
         end
         S_START: begin
            if (cnt_zero) begin
               cnt_d     = CNT_FULL;
               bit_idx_d = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_zero) begin
               cnt_d     = CNT_FULL;
               shift_d   = {rx_sync_q, shift_q[7:1]};   // LSB arrives first
               bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef PARITY_EN
         S_PAR: begin
            if (cnt_zero) begin
               cnt_d     = CNT_FULL;
               par_err_d = rx_sync_q ^ (^shift_q);      // even parity
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (cnt_zero) begin
`ifdef PARITY_EN
               byte_ok  = rx_sync_q && !par_err_q;
`else
               byte_ok  = rx_sync_q;
`endif
               byte_bad = !byte_ok;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: cnt_d = '0;
      endcase

      // A bad frame also drops a half-assembled word.
      if (byte_bad) begin
         ferr_d     = 1'b1;
         hi_phase_d = 1'b1;
      end else if (byte_ok && !done_q) begin
         if (hi_phase_q) begin
            hi_byte_d  = shift_q;
            hi_phase_d = 1'b0;
         end else begin
            we_d       = 1'b1;
            addr_d     = words_q[ADDR_W-1:0];
            data_d     = {hi_byte_q, shift_q};
            words_d    = words_inc;
            hi_phase_d = 1'b1;
            if (words_inc == (ADDR_W+1)'(WORD_COUNT)) done_d = 1'b1;
         end
      end
   end

   // Outputs straight from registers.
   always_comb begin
      mem.write_enable_to_mem = we_q;
      mem.address_to_mem      = addr_q;
      mem.data_to_mem         = data_q;
      load_done               = done_q;
      frame_err               = ferr_q;
      words_loaded            = words_q;
   end

endmodule

// File: tb/tb_uart_rx_code_loader.sv
module tb_uart_rx_code_loader;

   localparam int CPB    = 16;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int WC     = 4;

   logic              clk;
   logic              reset;
   logic              uart_rx;
   logic              load_done;
   logic              frame_err;
   logic [ADDR_W:0]   words_loaded;

   uart_rx_code_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

   uart_rx_code_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .WORD_COUNT  (WC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .uart_rx     (uart_rx),
      .mem         (mem_if.master),
      .load_done   (load_done),
      .frame_err   (frame_err),
      .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Write monitor: captures every strobe and flags strobes longer than one cycle.
   logic [ADDR_W-1:0] wr_addr[$];
   logic [DATA_W-1:0] wr_data[$];
   logic              we_prev = 1'b0;
   int                long_pulses = 0;

   always @(negedge clk) begin
      if (mem_if.write_enable_to_mem) begin
         wr_addr.push_back(mem_if.address_to_mem);
         wr_data.push_back(mem_if.data_to_mem);
         if (we_prev) long_pulses++;
      end
      we_prev <= mem_if.write_enable_to_mem;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tx_bit(input logic b);
      uart_rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      uart_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // One frame; par_ok=0 sends the wrong parity bit when parity is built in.
   task automatic send(input logic [7:0] b, input logic stop, input logic par_ok);
      tx_bit(1'b0);
      for (int i = 0; i < 8; i++) tx_bit(b[i]);
`ifdef PARITY_EN
      tx_bit(par_ok ? ^b : ~^b);
`else
      if (!par_ok) uart_rx = 1'b1;
`endif
      tx_bit(stop);
   endtask

   task automatic do_reset();
      uart_rx = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic check_one_write(input string tag, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d);
      check({tag, "_nwr"}, wr_addr.size(), 1);
      if (wr_addr.size() >= 1) begin
         check({tag, "_addr"}, wr_addr[0], a);
         check({tag, "_data"}, wr_data[0], d);
      end
   endtask

   logic [15:0] exp_words [4];

   initial begin
      exp_words[0] = 16'hA55A;
      exp_words[1] = 16'h00FF;
      exp_words[2] = 16'hDEAD;
      exp_words[3] = 16'hBEEF;

      reset   = 1'b0;
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_we",    mem_if.write_enable_to_mem, 0);
      check("rst_addr",  mem_if.address_to_mem, 0);
      check("rst_data",  mem_if.data_to_mem, 0);
      check("rst_done",  load_done, 0);
      check("rst_ferr",  frame_err, 0);
      check("rst_words", words_loaded, 0);
      reset = 1'b1;
      idle(4);

      // 1: single word
      do_reset();
      send(8'h12, 1'b1, 1'b1);
      send(8'h34, 1'b1, 1'b1);
      idle(2 * CPB);
      check_one_write("t1", 0, 16'h1234);
      check("t1_words", words_loaded, 1);
      check("t1_done",  load_done, 0);

      // 2: back-to-back full image, then extra bytes after done
      do_reset();
      send(8'hA5, 1'b1, 1'b1); send(8'h5A, 1'b1, 1'b1);
      send(8'h00, 1'b1, 1'b1); send(8'hFF, 1'b1, 1'b1);
      send(8'hDE, 1'b1, 1'b1); send(8'hAD, 1'b1, 1'b1);
      send(8'hBE, 1'b1, 1'b1); send(8'hEF, 1'b1, 1'b1);
      idle(2 * CPB);
      check("t2_nwr", wr_addr.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < wr_addr.size()) begin
            check($sformatf("t2_addr%0d", i), wr_addr[i], i);
            check($sformatf("t2_data%0d", i), wr_data[i], exp_words[i]);
         end
      end
      check("t2_done",  load_done, 1);
      check("t2_words", words_loaded, 4);
      send(8'h11, 1'b1, 1'b1);
      send(8'h22, 1'b1, 1'b1);
      idle(2 * CPB);
      check("t2_nwr_after",   wr_addr.size(), 4);
      check("t2_words_after", words_loaded, 4);
      check("t2_addr_hold",   mem_if.address_to_mem, 3);
      check("t2_data_hold",   mem_if.data_to_mem, 16'hBEEF);
      check("t2_ferr",        frame_err, 0);

      // 3: bad stop bit drops the partial word
      do_reset();
      send(8'h12, 1'b1, 1'b1);
      send(8'h34, 1'b0, 1'b1);
      idle(2 * CPB);
      check("t3_ferr_mid", frame_err, 1);
      check("t3_nwr_mid",  wr_addr.size(), 0);
      send(8'h56, 1'b1, 1'b1);
      send(8'h78, 1'b1, 1'b1);
      idle(2 * CPB);
      check_one_write("t3", 0, 16'h5678);
      check("t3_ferr",  frame_err, 1);
      check("t3_words", words_loaded, 1);

      // 4: quarter-bit glitch while idle
      do_reset();
      uart_rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      idle(3 * CPB);
      check("t4_ferr",  frame_err, 0);
      check("t4_nwr",   wr_addr.size(), 0);
      check("t4_words", words_loaded, 0);
      send(8'hC3, 1'b1, 1'b1);
      send(8'h3C, 1'b1, 1'b1);
      idle(2 * CPB);
      check_one_write("t4", 0, 16'hC33C);

      // 5: async reset in the middle of the second byte of a word
      do_reset();
      send(8'hAB, 1'b1, 1'b1);
      send(8'hCD, 1'b1, 1'b1);
      idle(CPB);
      send(8'h11, 1'b1, 1'b1);
      tx_bit(1'b0);
      tx_bit(1'b1);
      tx_bit(1'b1);
      #2 reset = 1'b0;
      #1;
      check("t5_rst_data",  mem_if.data_to_mem, 0);
      check("t5_rst_words", words_loaded, 0);
      check("t5_rst_addr",  mem_if.address_to_mem, 0);
      check("t5_rst_we",    mem_if.write_enable_to_mem, 0);
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
      send(8'h11, 1'b1, 1'b1);
      send(8'h22, 1'b1, 1'b1);
      idle(2 * CPB);
      check_one_write("t5", 0, 16'h1122);
      check("t5_ferr", frame_err, 0);

`ifdef PARITY_EN
      // 6: parity error treated as a bad frame
      do_reset();
      send(8'h01, 1'b1, 1'b0);
      idle(2 * CPB);
      check("t6_ferr", frame_err, 1);
      check("t6_nwr0", wr_addr.size(), 0);
      send(8'h03, 1'b1, 1'b1);
      send(8'h03, 1'b1, 1'b1);
      idle(2 * CPB);
      check_one_write("t6", 0, 16'h0303);
`endif

      check("strobe_width", long_pulses, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_code_loader.md
Name: uart_rx_code_loader

Overview:
UART receiver and word assembler that loads the program image into code memory over a serial line. It is the receive-side counterpart of the RAM readout/UART transmit path. It deserialises 8N1 frames, packs byte pairs into 16-bit words and writes them to sequential code-memory addresses. After the configured word count it asserts load_done, which holds the CPU in reset until loading is complete.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4
ADDR_W, 6, code-memory address width
DATA_W, 16, memory word width; fixed at 2 bytes
WORD_COUNT, 64, words to load before load_done; 1..2^ADDR_W

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
uart_rx  input  1  serial input, idle high, asynchronous to clk
write_enable_to_mem  output  1  single-cycle write strobe
address_to_mem  output  ADDR_W  write address
data_to_mem  output  DATA_W  write data
load_done  output  1  sticky; all WORD_COUNT words written
frame_err  output  1  sticky; at least one bad frame seen
words_loaded  output  ADDR_W+1  number of words written so far

Behaviour:
- reset low (async): all outputs 0, FSM to IDLE, byte phase = high, word counter 0. Synchroniser flops reset to 1. Reset mid-frame or mid-word discards all partial data.
- uart_rx passes through a 2-flop synchroniser before any use; all timing below refers to the synchronised signal.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronised rx = 0; bit counter loaded with CLKS_PER_BIT/2 - 1.
  - START: at counter expiry, sample rx. 0 -> DATA with bit index 0 and counter CLKS_PER_BIT-1. 1 -> IDLE (glitch rejected, no error).
  - DATA: every CLKS_PER_BIT cycles sample one bit, LSB first. After bit 7 -> STOP.
  - STOP: sample at mid-bit, then return to IDLE on the next cycle so back-to-back frames are accepted.
    - rx = 1: byte valid.
    - rx = 0: frame_err set, byte discarded, byte phase reset to high (partial word dropped).
- Word assembly is big-endian.
  - First valid byte -> data[15:8].
  - Second valid byte -> data[7:0].
- Write timing: write_enable_to_mem pulses high for exactly one cycle, on the cycle after the stop-bit sample of the low byte.
  - address_to_mem and data_to_mem are valid in that same cycle and hold their value until the next write.
  - Address equals words_loaded before the increment; the first word goes to address 0.
- words_loaded increments on each write.
  - When it reaches WORD_COUNT, load_done goes high in the same cycle as the final write strobe's following edge and stays high until reset.
  - With WORD_COUNT = 2^ADDR_W the address never wraps, because no writes occur after done.
- After load_done: frames are still received and checked (frame_err can still set), but no writes occur and the counters are frozen.
- frame_err clears only on reset.

Optional Feature:
PARITY_EN
- Defined: frame becomes 8E1. A DATA_PAR state sits between DATA and STOP and samples an even-parity bit. A parity mismatch is treated exactly like a framing error: frame_err set, byte discarded, byte phase reset.
- Undefined: 8N1, with no parity state or logic.

Test Plan:
All cases use CLKS_PER_BIT=16, WORD_COUNT=4.
1. Send bytes 0x12, 0x34 -> one write_enable_to_mem pulse, address 0, data 0x1234, words_loaded=1, load_done=0.
2. Send 8 bytes 0xA5 0x5A 0x00 0xFF 0xDE 0xAD 0xBE 0xEF back-to-back with no idle gap -> writes of 0xA55A@0, 0x00FF@1, 0xDEAD@2, 0xBEEF@3. load_done=1 after the 4th write. Two further bytes produce no write.
3. Send 0x12, then 0x34 with the stop bit forced 0, then 0x56, 0x78 -> frame_err=1, no write for the partial word, single write 0x5678@0.
4. 0.25-bit low glitch on uart_rx while idle -> no state change, frame_err=0, no write. A following valid 0xC3 0x3C -> write 0xC33C@0.
5. Assert reset low mid-way through the 2nd byte of a word -> all outputs 0 immediately. After release, 0x11 0x22 -> write 0x1122@0.
6. With PARITY_EN defined: 0x01 with parity bit 0 -> frame_err=1, byte dropped. 0x03 0x03 with parity bits 0 -> write 0x0303@0.
